// File: rtl/issue_queue_pkg.sv
// Shared definitions for the collapsing issue queue: default sizes, the entry
// record and the wakeup tag-match helper.
package issue_queue_pkg;

    localparam int IQ_SIZE_DEF = 8;
    localparam int PREG_W_DEF  = 6;
    localparam int UOP_W_DEF   = 32;

    typedef struct packed {
        logic                  valid;
        logic [UOP_W_DEF-1:0]  uop;
        logic [PREG_W_DEF-1:0] rs1;
        logic                  rs1Rdy;
        logic [PREG_W_DEF-1:0] rs2;
        logic                  rs2Rdy;
    } iq_entry_t;

    // True when either wakeup port broadcasts the given tag this cycle.
    function automatic logic tagWoken(
        input logic [PREG_W_DEF-1:0]      tag,
        input logic [1:0]                 wakeValid,
        input logic [1:0][PREG_W_DEF-1:0] wakeTag
    );
        return (wakeValid[0] && (wakeTag[0] == tag)) ||
               (wakeValid[1] && (wakeTag[1] == tag));
    endfunction

endpackage

// File: rtl/issue_queue_select.sv
// Oldest-ready priority finder: returns the lowest index with its ready bit set.
module iq_select
    import issue_queue_pkg::*;
#(
    parameter int N     = IQ_SIZE_DEF,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_ready,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Scan from the youngest down so the oldest ready entry wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_ready[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Collapsing issue queue: two-wide dispatch, two wakeup ports, one issue port.
// Entry 0 is always the oldest; issued entries collapse younger ones down.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int IQ_SIZE = IQ_SIZE_DEF,
    parameter int PREG_W  = PREG_W_DEF,
    parameter int UOP_W   = UOP_W_DEF
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [1:0]                       dispatch_valid,
    input  logic [1:0][UOP_W-1:0]            dispatch_uop,
    input  logic [1:0][PREG_W-1:0]           dispatch_rs1,
    input  logic [1:0][PREG_W-1:0]           dispatch_rs2,
    input  logic [1:0]                       dispatch_rs1_ready,
    input  logic [1:0]                       dispatch_rs2_ready,
    output logic                             dispatch_ready,
    input  logic [1:0]                       wakeup_valid,
    input  logic [1:0][PREG_W-1:0]           wakeup_tag,
    output logic                             issue_valid,
    output logic [UOP_W-1:0]                 issue_uop,
    input  logic                             issue_ready,
    output logic [$clog2(IQ_SIZE+1)-1:0]     count
);

    localparam int CNT_W = $clog2(IQ_SIZE + 1);
    localparam int IDX_W = (IQ_SIZE > 1) ? $clog2(IQ_SIZE) : 1;

    iq_entry_t        r_entries [IQ_SIZE];
    logic [CNT_W-1:0] r_count;

    iq_entry_t        w_woken [IQ_SIZE];
    iq_entry_t        w_next  [IQ_SIZE];
    iq_entry_t        w_new   [2];
    logic [IQ_SIZE-1:0] w_ready;
    logic [IDX_W-1:0] w_selIdx;
    logic             w_found;
    logic             w_fire;
    logic             w_acc0;
    logic             w_acc1;
    logic [CNT_W-1:0] w_postCount;
    logic [CNT_W-1:0] w_countNext;

    always_comb begin
        for (int i = 0; i < IQ_SIZE; i++) begin
            w_ready[i] = r_entries[i].valid && r_entries[i].rs1Rdy && r_entries[i].rs2Rdy;
        end
    end

    iq_select #(
        .N     (IQ_SIZE),
        .IDX_W (IDX_W)
    ) u_select (
        .i_ready (w_ready),
        .o_idx   (w_selIdx),
        .o_found (w_found)
    );

    assign dispatch_ready = (r_count <= CNT_W'(IQ_SIZE - 2)) && !flush;
    assign issue_valid    = w_found && !flush;
    assign issue_uop      = r_entries[w_selIdx].uop;
    assign count          = r_count;

    assign w_fire      = issue_valid && issue_ready;
    assign w_acc0      = dispatch_valid[0] && dispatch_ready;
    assign w_acc1      = dispatch_valid[1] && dispatch_ready;
    assign w_postCount = r_count - CNT_W'(w_fire);
    assign w_countNext = w_postCount + CNT_W'(w_acc0) + CNT_W'(w_acc1);

    // Incoming uops: tag 0 and same-cycle wakeups count as ready on capture.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_new[k].valid  = 1'b1;
            w_new[k].uop    = dispatch_uop[k];
            w_new[k].rs1    = dispatch_rs1[k];
            w_new[k].rs2    = dispatch_rs2[k];
            w_new[k].rs1Rdy = dispatch_rs1_ready[k] || (dispatch_rs1[k] == '0) ||
                              tagWoken(dispatch_rs1[k], wakeup_valid, wakeup_tag);
            w_new[k].rs2Rdy = dispatch_rs2_ready[k] || (dispatch_rs2[k] == '0) ||
                              tagWoken(dispatch_rs2[k], wakeup_valid, wakeup_tag);
        end
    end

    // Next queue image: apply wakeups, collapse out the issued entry, then append.
    always_comb begin
        for (int i = 0; i < IQ_SIZE; i++) begin
            w_woken[i] = r_entries[i];
            if (tagWoken(r_entries[i].rs1, wakeup_valid, wakeup_tag)) begin
                w_woken[i].rs1Rdy = 1'b1;
            end
            if (tagWoken(r_entries[i].rs2, wakeup_valid, wakeup_tag)) begin
                w_woken[i].rs2Rdy = 1'b1;
            end
        end

        w_next = w_woken;
        for (int i = 0; i < IQ_SIZE - 1; i++) begin
            if (w_fire && (IDX_W'(i) >= w_selIdx)) begin
                w_next[i] = w_woken[i + 1];
            end
        end
        if (w_fire) begin
            w_next[IQ_SIZE - 1].valid = 1'b0;
        end

        for (int i = 0; i < IQ_SIZE; i++) begin
            if (w_acc0 && (CNT_W'(i) == w_postCount)) begin
                w_next[i] = w_new[0];
            end
            if (w_acc1 && (CNT_W'(i) == (w_postCount + CNT_W'(w_acc0)))) begin
                w_next[i] = w_new[1];
            end
        end
    end

    // Only valid bits and the count are reset; payload and tags are don't-care.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < IQ_SIZE; i++) begin
                r_entries[i].valid <= 1'b0;
            end
            r_count <= '0;
        end else if (flush) begin
            for (int i = 0; i < IQ_SIZE; i++) begin
                r_entries[i].valid <= 1'b0;
            end
            r_count <= '0;
        end else begin
            r_entries <= w_next;
            r_count   <= w_countNext;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: a scoreboard holds the expected issue
// order and is popped whenever an issue handshake is observed.
module tb_issue_queue;

    logic                 clock;
    logic                 reset;
    logic                 flush;
    logic [1:0]           dispatch_valid;
    logic [1:0][31:0]     dispatch_uop;
    logic [1:0][5:0]      dispatch_rs1;
    logic [1:0][5:0]      dispatch_rs2;
    logic [1:0]           dispatch_rs1_ready;
    logic [1:0]           dispatch_rs2_ready;
    logic                 dispatch_ready;
    logic [1:0]           wakeup_valid;
    logic [1:0][5:0]      wakeup_tag;
    logic                 issue_valid;
    logic [31:0]          issue_uop;
    logic                 issue_ready;
    logic [3:0]           count;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] sb [$];
    logic [31:0] uArr [8];

    issue_queue #(
        .IQ_SIZE (8),
        .PREG_W  (6),
        .UOP_W   (32)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .flush              (flush),
        .dispatch_valid     (dispatch_valid),
        .dispatch_uop       (dispatch_uop),
        .dispatch_rs1       (dispatch_rs1),
        .dispatch_rs2       (dispatch_rs2),
        .dispatch_rs1_ready (dispatch_rs1_ready),
        .dispatch_rs2_ready (dispatch_rs2_ready),
        .dispatch_ready     (dispatch_ready),
        .wakeup_valid       (wakeup_valid),
        .wakeup_tag         (wakeup_tag),
        .issue_valid        (issue_valid),
        .issue_uop          (issue_uop),
        .issue_ready        (issue_ready),
        .count              (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int k, input logic [31:0] uop, input logic [5:0] r1,
                                 input logic r1Rdy, input logic [5:0] r2, input logic r2Rdy);
        dispatch_valid[k]     = 1'b1;
        dispatch_uop[k]       = uop;
        dispatch_rs1[k]       = r1;
        dispatch_rs1_ready[k] = r1Rdy;
        dispatch_rs2[k]       = r2;
        dispatch_rs2_ready[k] = r2Rdy;
    endtask

    task automatic wake(input int p, input logic [5:0] tag);
        wakeup_valid[p] = 1'b1;
        wakeup_tag[p]   = tag;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
        dispatch_valid = '0;
        wakeup_valid   = '0;
        flush          = 1'b0;
    endtask

    // Issue handshakes are observed at the falling edge, ahead of the edge that commits them.
    always @(negedge clock) begin
        if (!reset && issue_valid && issue_ready) begin
            if (sb.size() == 0) begin
                checkOutput("sbUnexpectedIssue", 32'(sb.size()), 32'd1);
            end else begin
                checkOutput("issueUop", issue_uop, sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) uArr[i] = 32'h5500_0000 + 32'(i);
        reset              = 1'b1;
        flush              = 1'b0;
        dispatch_valid     = '0;
        dispatch_uop       = '0;
        dispatch_rs1       = '0;
        dispatch_rs2       = '0;
        dispatch_rs1_ready = '0;
        dispatch_rs2_ready = '0;
        wakeup_valid       = '0;
        wakeup_tag         = '0;
        issue_ready        = 1'b0;

        @(negedge clock);
        checkOutput("rstCount", 32'(count), 32'd0);
        checkOutput("rstIssueValid", 32'(issue_valid), 32'd0);
        checkOutput("rstDispatchReady", 32'(dispatch_ready), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        $display("[TB] two ready uops issue back to back");
        issue_ready = 1'b1;
        sb.push_back(32'hA000_0000);
        sb.push_back(32'hA000_0001);
        applyStimulus(0, 32'hA000_0000, 6'd1, 1'b1, 6'd2, 1'b1);
        applyStimulus(1, 32'hA000_0001, 6'd3, 1'b1, 6'd4, 1'b1);
        @(negedge clock);
        checkOutput("s1DispReady", 32'(dispatch_ready), 32'd1);
        checkOutput("s1EmptyIssueValid", 32'(issue_valid), 32'd0);
        stepCycle();
        @(negedge clock);
        checkOutput("s1Count2", 32'(count), 32'd2);
        checkOutput("s1IssueValid", 32'(issue_valid), 32'd1);
        stepCycle();
        @(negedge clock);
        checkOutput("s1Count1", 32'(count), 32'd1);
        stepCycle();
        @(negedge clock);
        checkOutput("s1Count0", 32'(count), 32'd0);
        checkOutput("s1DrainedIssueValid", 32'(issue_valid), 32'd0);
        stepCycle();

        $display("[TB] younger ready uop bypasses older waiting uop");
        sb.push_back(32'hB000_000B);
        sb.push_back(32'hB000_000A);
        applyStimulus(0, 32'hB000_000A, 6'd5, 1'b0, 6'd0, 1'b0);
        applyStimulus(1, 32'hB000_000B, 6'd6, 1'b1, 6'd7, 1'b1);
        @(negedge clock);
        stepCycle();
        @(negedge clock);
        checkOutput("s2BIssueValid", 32'(issue_valid), 32'd1);
        stepCycle();
        @(negedge clock);
        checkOutput("s2ACount", 32'(count), 32'd1);
        checkOutput("s2AWaiting", 32'(issue_valid), 32'd0);
        stepCycle();
        wake(0, 6'd5);
        @(negedge clock);
        checkOutput("s2NoBypass", 32'(issue_valid), 32'd0);
        stepCycle();
        @(negedge clock);
        checkOutput("s2AWokenValid", 32'(issue_valid), 32'd1);
        stepCycle();
        @(negedge clock);
        checkOutput("s2Count0", 32'(count), 32'd0);
        stepCycle();

        $display("[TB] fill to capacity, then collapse with simultaneous dispatch");
        issue_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            applyStimulus(0, uArr[2*p],     6'(20 + 2*p), 1'b0, 6'd0, 1'b0);
            applyStimulus(1, uArr[2*p + 1], 6'(21 + 2*p), 1'b0, 6'd0, 1'b0);
            @(negedge clock);
            checkOutput("s3FillDispReady", 32'(dispatch_ready), 32'd1);
            stepCycle();
        end
        applyStimulus(0, 32'hDEAD_0000, 6'd1, 1'b1, 6'd2, 1'b1);
        applyStimulus(1, 32'hDEAD_0001, 6'd1, 1'b1, 6'd2, 1'b1);
        @(negedge clock);
        checkOutput("s3Count8", 32'(count), 32'd8);
        checkOutput("s3FullDispReady", 32'(dispatch_ready), 32'd0);
        checkOutput("s3FullIssueValid", 32'(issue_valid), 32'd0);
        stepCycle();
        issue_ready = 1'b1;
        sb.push_back(uArr[2]);
        wake(0, 6'd22);
        @(negedge clock);
        checkOutput("s3Count8Held", 32'(count), 32'd8);
        checkOutput("s3WakeNoBypass", 32'(issue_valid), 32'd0);
        stepCycle();
        @(negedge clock);
        checkOutput("s3U2IssueValid", 32'(issue_valid), 32'd1);
        stepCycle();
        sb.push_back(uArr[3]);
        wake(0, 6'd23);
        @(negedge clock);
        checkOutput("s3Count7", 32'(count), 32'd7);
        checkOutput("s3Count7DispReady", 32'(dispatch_ready), 32'd0);
        stepCycle();
        @(negedge clock);
        stepCycle();
        sb.push_back(uArr[0]);
        wake(0, 6'd20);
        @(negedge clock);
        checkOutput("s3Count6", 32'(count), 32'd6);
        stepCycle();
        applyStimulus(0, 32'hC000_0000, 6'd1, 1'b1, 6'd2, 1'b1);
        applyStimulus(1, 32'hC000_0001, 6'd3, 1'b1, 6'd4, 1'b1);
        @(negedge clock);
        checkOutput("s3Count6DispReady", 32'(dispatch_ready), 32'd1);
        checkOutput("s3FireWithDispatch", 32'(issue_valid), 32'd1);
        stepCycle();
        issue_ready = 1'b0;
        wake(0, 6'd21);
        wake(1, 6'd24);
        @(negedge clock);
        checkOutput("s3CountAfterBoth", 32'(count), 32'd7);
        checkOutput("s3HeldValid", 32'(issue_valid), 32'd1);
        checkOutput("s3HeldUop", issue_uop, 32'hC000_0000);
        stepCycle();
        wake(0, 6'd25);
        wake(1, 6'd26);
        @(negedge clock);
        checkOutput("s3OlderWins", issue_uop, uArr[1]);
        stepCycle();
        wake(0, 6'd27);
        @(negedge clock);
        stepCycle();
        sb.push_back(uArr[1]);
        sb.push_back(uArr[4]);
        sb.push_back(uArr[5]);
        sb.push_back(uArr[6]);
        sb.push_back(uArr[7]);
        sb.push_back(32'hC000_0000);
        sb.push_back(32'hC000_0001);
        issue_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            stepCycle();
        end
        @(negedge clock);
        checkOutput("s3DrainCount", 32'(count), 32'd0);
        stepCycle();

        $display("[TB] same-cycle wakeup captured on dispatch");
        sb.push_back(32'hE000_0009);
        applyStimulus(0, 32'hE000_0009, 6'd0, 1'b0, 6'd9, 1'b0);
        wake(1, 6'd9);
        @(negedge clock);
        stepCycle();
        @(negedge clock);
        checkOutput("s4CapturedReady", 32'(issue_valid), 32'd1);
        stepCycle();
        @(negedge clock);
        checkOutput("s4Count0", 32'(count), 32'd0);
        stepCycle();

        $display("[TB] flush and asynchronous reset");
        issue_ready = 1'b0;
        applyStimulus(0, 32'hF000_0000, 6'd1, 1'b1, 6'd2, 1'b1);
        applyStimulus(1, 32'hF000_0001, 6'd3, 1'b1, 6'd4, 1'b1);
        @(negedge clock);
        stepCycle();
        applyStimulus(0, 32'hF000_0002, 6'd40, 1'b0, 6'd0, 1'b0);
        applyStimulus(1, 32'hF000_0003, 6'd41, 1'b0, 6'd0, 1'b0);
        @(negedge clock);
        stepCycle();
        applyStimulus(0, 32'hF000_0004, 6'd42, 1'b0, 6'd0, 1'b0);
        @(negedge clock);
        stepCycle();
        issue_ready = 1'b1;
        flush = 1'b1;
        applyStimulus(0, 32'hF100_0000, 6'd1, 1'b1, 6'd2, 1'b1);
        applyStimulus(1, 32'hF100_0001, 6'd1, 1'b1, 6'd2, 1'b1);
        wake(0, 6'd40);
        @(negedge clock);
        checkOutput("s5FlushCount5", 32'(count), 32'd5);
        checkOutput("s5FlushIssueValid", 32'(issue_valid), 32'd0);
        checkOutput("s5FlushDispReady", 32'(dispatch_ready), 32'd0);
        stepCycle();
        issue_ready = 1'b0;
        @(negedge clock);
        checkOutput("s5PostFlushCount", 32'(count), 32'd0);
        checkOutput("s5PostFlushIssueValid", 32'(issue_valid), 32'd0);
        stepCycle();
        applyStimulus(0, 32'hF200_0000, 6'd1, 1'b1, 6'd2, 1'b1);
        applyStimulus(1, 32'hF200_0001, 6'd3, 1'b1, 6'd4, 1'b1);
        @(negedge clock);
        stepCycle();
        @(negedge clock);
        checkOutput("s5PreResetCount", 32'(count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("s5AsyncResetCount", 32'(count), 32'd0);
        checkOutput("s5AsyncResetIssueValid", 32'(issue_valid), 32'd0);
        checkOutput("s5AsyncResetDispReady", 32'(dispatch_ready), 32'd1);
        #1;
        reset = 1'b0;
        stepCycle();
        @(negedge clock);
        checkOutput("s5PostResetCount", 32'(count), 32'd0);
        stepCycle();

        checkOutput("sbEmpty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
